// File: rtl/mem_pkg.sv
// Shared line-memory geometry and responder state encoding.
// Used by line_mem_responder and by mem_top for the cache line layout.
package mem_pkg;

  // Responder FSM states.
  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RBURST,
    WBURST,
    WDONE
  } resp_state_t;

  // Default line geometry: 4 words of 4 bytes per line.
  localparam int DEF_LINE_WORDS   = 4;
  localparam int BEAT_BITS        = $clog2(DEF_LINE_WORDS);
  localparam int LINE_OFFSET_BITS = $clog2(DEF_LINE_WORDS) + 2;

  // Width of a beat index for a given line size. Never returns 0, so a
  // degenerate line still yields a legal vector width.
  function automatic int beat_bits(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-addressed storage: one synchronous write port, one asynchronous read
// port. Contents are never reset, so they survive a responder reset.
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write word address
//   wdata_i  : write data
//   raddr_i  : read word address
//   rdata_o  : read data (combinational)
module mem_word_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/line_mem_responder.sv
// Backing-memory responder for the data cache line-fill / write-back port.
// Accepts one line request at a time, waits a fixed latency, then moves
// LINE_WORDS beats with per-beat handshakes.
//   req_valid_i/req_ready_o      : request handshake (req_write_i, req_addr_i)
//   wdata_i/wdata_valid_i/wdata_ready_o : write-back beats
//   rdata_o/rdata_valid_o/rdata_ready_i/rdata_last_o : refill beats
//   wr_done_o : one-cycle pulse once a write-back line is committed
//   busy_o    : responder not idle
//
// state  | meaning
// IDLE   | ready for a new request
// WAIT   | modelling access latency (down-counter to 0)
// RBURST | streaming refill beats to the cache
// WBURST | absorbing write-back beats from the cache
// WDONE  | write-back committed, pulse wr_done_o
module line_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rdata_valid_o,
  input  logic                  rdata_ready_i,
  output logic                  rdata_last_o,
  output logic                  wr_done_o,
  output logic                  busy_o
);

  localparam int BEAT_W = beat_bits(LINE_WORDS);
  localparam int OFF_W  = BEAT_W + 2;
  localparam int WORD_W = ADDR_WIDTH - 2;
  localparam int LINE_W = WORD_W - BEAT_W;
  localparam int DEPTH  = 1 << WORD_W;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY - 1);

  resp_state_t        state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic               write_q, write_d;

  logic                  mem_we;
  logic [WORD_W-1:0]     word_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Byte offset within the line never reaches the array.
  logic unused_offset;
  assign unused_offset = ^req_addr_i[OFF_W-1:0];

  // Concatenation (not addition) keeps a burst inside its line, and the top
  // line simply wraps within the array.
  assign word_addr = {line_q, beat_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      line_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lat_d         = lat_q;
    beat_d        = beat_q;
    line_d        = line_q;
    write_d       = write_q;
    req_ready_o   = 1'b0;
    wdata_ready_o = 1'b0;
    rdata_valid_o = 1'b0;
    rdata_last_o  = 1'b0;
    wr_done_o     = 1'b0;
    mem_we        = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          line_d  = req_addr_i[ADDR_WIDTH-1:OFF_W];
          write_d = req_write_i;
          lat_d   = LAT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          beat_d  = '0;
          state_d = write_q ? WBURST : RBURST;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RBURST: begin
        rdata_valid_o = 1'b1;
        rdata_last_o  = (beat_q == LAST_BEAT);
        if (rdata_ready_i) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = IDLE;
        end
      end
      WBURST: begin
        wdata_ready_o = 1'b1;
        if (wdata_valid_i) begin
          mem_we = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = WDONE;
        end
      end
      WDONE: begin
        wr_done_o = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o  = (state_q != IDLE);
  // Gated so the refill bus reads zero whenever no beat is offered.
  assign rdata_o = (state_q == RBURST) ? mem_rdata : '0;

  mem_word_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (WORD_W)
  ) u_array (
    .clk    (clk),
    .we_i   (mem_we),
    .waddr_i(word_addr),
    .wdata_i(wdata_i),
    .raddr_i(word_addr),
    .rdata_o(mem_rdata)
  );

endmodule

// File: tb/tb_line_mem_responder.sv
module tb_line_mem_responder;

  typedef logic [31:0] line_t [4];

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready_o;
  logic        req_write;
  logic [11:0] req_addr;
  logic [31:0] wdata;
  logic        wdata_valid;
  logic        wdata_ready_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        rdata_ready;
  logic        rdata_last_o;
  logic        wr_done_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  line_mem_responder #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(32),
    .LINE_WORDS(4),
    .LATENCY   (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .wdata_i      (wdata),
    .wdata_valid_i(wdata_valid),
    .wdata_ready_o(wdata_ready_o),
    .rdata_o      (rdata_o),
    .rdata_valid_o(rdata_valid_o),
    .rdata_ready_i(rdata_ready),
    .rdata_last_o (rdata_last_o),
    .wr_done_o    (wr_done_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},   {31'd0, req_ready_o},   32'd1);
    chk({tag, "_wdata_ready"}, {31'd0, wdata_ready_o}, 32'd0);
    chk({tag, "_rvalid"},      {31'd0, rdata_valid_o}, 32'd0);
    chk({tag, "_rlast"},       {31'd0, rdata_last_o},  32'd0);
    chk({tag, "_wr_done"},     {31'd0, wr_done_o},     32'd0);
    chk({tag, "_busy"},        {31'd0, busy_o},        32'd0);
    chk({tag, "_rdata"},       rdata_o,                32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle
  // again (or, when aborted, #1 after asserting reset).
  task automatic do_write(input logic [11:0] a, input line_t d,
                          input int gap_at, input int gap_len, input int abort_at);
    int n;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = a;
    @(negedge clk);
    req_valid = 1'b0;
    chk("wr_req_ready_low", {31'd0, req_ready_o}, 32'd0);
    n = 0;
    while (!wdata_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wr_latency", n, 32'd4);
    for (int b = 0; b < 4; b++) begin
      if (b == abort_at) begin
        wdata_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        return;
      end
      if (b == gap_at) begin
        wdata_valid = 1'b0;
        repeat (gap_len) begin
          @(negedge clk);
          chk("wr_gap_ready", {31'd0, wdata_ready_o}, 32'd1);
        end
      end
      wdata_valid = 1'b1;
      wdata       = d[b];
      chk("wr_done_early", {31'd0, wr_done_o}, 32'd0);
      @(negedge clk);
    end
    wdata_valid = 1'b0;
    chk("wr_done_pulse", {31'd0, wr_done_o}, 32'd1);
    @(negedge clk);
    chk("wr_done_clear", {31'd0, wr_done_o}, 32'd0);
    chk("wr_idle_busy",  {31'd0, busy_o},    32'd0);
  endtask

  task automatic do_read(input logic [11:0] a, input line_t e,
                         input int bp_at, input int bp_len,
                         input bit hold_next, input logic [11:0] next_a);
    int n;
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_addr    = a;
    rdata_ready = 1'b1;
    @(negedge clk);
    if (hold_next) req_addr = next_a;
    else req_valid = 1'b0;
    chk("rd_busy", {31'd0, busy_o}, 32'd1);
    n = 0;
    while (!rdata_valid_o && n < 20) begin
      if (hold_next) chk("rd_wait_req_ready", {31'd0, req_ready_o}, 32'd0);
      @(negedge clk);
      n++;
    end
    chk("rd_latency", n, 32'd4);
    for (int b = 0; b < 4; b++) begin
      if (b == bp_at) begin
        rdata_ready = 1'b0;
        repeat (bp_len) begin
          chk("bp_data",  rdata_o, e[b]);
          chk("bp_valid", {31'd0, rdata_valid_o}, 32'd1);
          @(negedge clk);
        end
        rdata_ready = 1'b1;
      end
      chk("rd_data",  rdata_o, e[b]);
      chk("rd_valid", {31'd0, rdata_valid_o}, 32'd1);
      chk("rd_last",  {31'd0, rdata_last_o}, (b == 3) ? 32'd1 : 32'd0);
      if (hold_next) chk("rd_burst_req_ready", {31'd0, req_ready_o}, 32'd0);
      @(negedge clk);
    end
    chk("rd_idle_busy",      {31'd0, busy_o},        32'd0);
    chk("rd_idle_valid",     {31'd0, rdata_valid_o}, 32'd0);
    chk("rd_idle_req_ready", {31'd0, req_ready_o},   32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    wdata       = '0;
    wdata_valid = 1'b0;
    rdata_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Preload mem[i] = 0x100 + i on the lines the tests touch.
    do_write(12'h000, '{32'h100, 32'h101, 32'h102, 32'h103}, -1, 0, -1);
    do_write(12'h010, '{32'h104, 32'h105, 32'h106, 32'h107}, -1, 0, -1);
    do_write(12'h040, '{32'h110, 32'h111, 32'h112, 32'h113}, -1, 0, -1);
    do_write(12'hFFC, '{32'h4FC, 32'h4FD, 32'h4FE, 32'h4FF}, -1, 0, -1);

    // Refill with line offset ignored.
    do_read(12'h014, '{32'h104, 32'h105, 32'h106, 32'h107}, -1, 0, 1'b0, 12'h000);

    // Backpressure on beat 1 for 3 cycles.
    do_read(12'h014, '{32'h104, 32'h105, 32'h106, 32'h107}, 1, 3, 1'b0, 12'h000);

    // Write-back with a gap before beat 2, then read it back.
    do_write(12'h020, '{32'hA0, 32'hA1, 32'hA2, 32'hA3}, 2, 2, -1);
    do_read(12'h020, '{32'hA0, 32'hA1, 32'hA2, 32'hA3}, -1, 0, 1'b0, 12'h000);

    // Second request held during WAIT/RBURST, taken on first IDLE cycle.
    do_read(12'h014, '{32'h104, 32'h105, 32'h106, 32'h107}, -1, 0, 1'b1, 12'h000);
    do_read(12'h000, '{32'h100, 32'h101, 32'h102, 32'h103}, -1, 0, 1'b0, 12'h000);

    // Reset after two write beats to line 0x040.
    do_write(12'h040, '{32'hB0, 32'hB1, 32'hB2, 32'hB3}, -1, 0, 2);
    @(negedge clk);
    chk_reset_outputs("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_wr_done", {31'd0, wr_done_o}, 32'd0);
    chk("post_reset_busy",    {31'd0, busy_o},    32'd0);
    do_read(12'h040, '{32'hB0, 32'hB1, 32'h112, 32'h113}, -1, 0, 1'b0, 12'h000);

    // Top line stays within its own words.
    do_read(12'hFFC, '{32'h4FC, 32'h4FD, 32'h4FE, 32'h4FF}, -1, 0, 1'b0, 12'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Backing-memory responder sitting behind the data cache (mem_top) on its line-fill/write-back port.
- Accepts one line request at a time (read refill or write-back) through a valid/ready handshake.
- Models fixed access latency, then transfers LINE_WORDS beats with per-beat handshakes.
- Owns the word-addressed storage array that the cache refills from.

Parameters:
- ADDR_WIDTH, 12, byte address width (matches cpu_addr_i[11:0]).
- DATA_WIDTH, 32, beat/word width.
- LINE_WORDS, 4, words per cache line; power of 2, ≥2.
- LATENCY, 4, wait cycles between request acceptance and first data phase; ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept a request.
- req_write_i  in  1  1 = write-back, 0 = refill.
- req_addr_i  in  ADDR_WIDTH  byte address; offset bits below the line are ignored.
- wdata_i  in  DATA_WIDTH  write-back beat.
- wdata_valid_i  in  1  write beat present.
- wdata_ready_o  out  1  write beat accepted this cycle when both are high.
- rdata_o  out  DATA_WIDTH  refill beat.
- rdata_valid_o  out  1  refill beat present.
- rdata_ready_i  in  1  cache accepts the refill beat.
- rdata_last_o  out  1  final beat of the line.
- wr_done_o  out  1  one-cycle pulse when a write-back is committed.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Storage array has 2^(ADDR_WIDTH-2) words. It is not reset, and its contents survive reset.
- Reset (async assert):
  - state=IDLE, beat counter=0, latency counter=0.
  - req_ready_o=1, wdata_ready_o=0, rdata_valid_o=0, rdata_last_o=0, wr_done_o=0, busy_o=0, rdata_o=0.
- FSM states: IDLE, WAIT, RBURST, WBURST, WDONE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&req_ready_o, latch line base = req_addr_i with the low log2(LINE_WORDS)+2 bits zeroed, latch req_write_i, load latency counter=LATENCY-1, go to WAIT.
- WAIT:
  - req_ready_o=0.
  - Decrement the latency counter each cycle.
  - At 0, go to RBURST (read) or WBURST (write), with beat counter=0.
  - Total cycles from the accept edge to the first RBURST/WBURST cycle = LATENCY.
- RBURST:
  - rdata_valid_o=1; rdata_o = mem[base_word+beat], read combinationally from the registered index.
  - rdata_last_o = (beat==LINE_WORDS-1).
  - The beat advances only on rdata_ready_i. With ready held high, all beats stream on consecutive cycles.
  - On the last beat accepted, go to IDLE.
  - rdata_o and rdata_valid_o hold stable while rdata_ready_i=0.
- WBURST:
  - wdata_ready_o=1.
  - On wdata_valid_i, write mem[base_word+beat] on that edge and increment beat.
  - Gaps in wdata_valid_i are allowed and do not advance the beat.
  - After the last beat is written, go to WDONE.
- WDONE:
  - wr_done_o=1 for exactly one cycle, then go to IDLE.
  - A read issued after wr_done_o returns the new data.
- Beat index is log2(LINE_WORDS) bits. The word address is base_word | beat, so a burst never crosses a line and never carries into tag bits.
- The top address line wraps naturally within the array; there is no out-of-range error.
- Simultaneous events:
  - req_valid_i outside IDLE is ignored, since ready=0. The requester must hold it.
  - wdata_valid_i outside WBURST is ignored.
- Reset mid-operation:
  - Abort to IDLE; no pulse is generated.
  - Write beats already committed remain in the array; remaining beats are lost.
- Back-to-back: IDLE is occupied for at least one cycle between requests, so the minimum request spacing = LATENCY+LINE_WORDS+1 cycles.

Decomposition:
- Shared package mem_pkg holds:
  - the enum resp_state_t {IDLE, WAIT, RBURST, WBURST, WDONE};
  - localparams LINE_OFFSET_BITS = $clog2(LINE_WORDS)+2 and BEAT_BITS.
- mem_top reuses the same package for the line geometry.
- One sub-module: mem_word_array (single write port, async read, DATA_WIDTH × DEPTH). The FSM/counters stay in line_mem_responder.

Test Plan:
- Refill, LATENCY=4, LINE_WORDS=4, array preloaded with 0x100+i at word i:
  - Stimulus: read at addr 0x014 with rdata_ready_i=1.
  - Response: beats 0x104, 0x105, 0x106, 0x107 start exactly 4 cycles after accept, on consecutive cycles; last beat is 0x107 with rdata_last_o=1; busy_o low the cycle after.
- Backpressure:
  - Stimulus: same read, with rdata_ready_i low on beat 1 for 3 cycles.
  - Response: rdata_o=0x105 held stable with rdata_valid_o=1; no beat skipped or duplicated.
- Write-back then read:
  - Stimulus: write to 0x020 with beats 0xA0..0xA3, a 2-cycle gap before beat 2; then read 0x020.
  - Response: wr_done_o pulses once, one cycle after beat 3; the read returns 0xA0..0xA3.
- Request while busy:
  - Stimulus: assert a second req_valid_i during WAIT and RBURST.
  - Response: req_ready_o=0 throughout; the second request is accepted on the first IDLE cycle; the first burst is unaffected.
- Reset mid-write:
  - Stimulus: assert rst_n low after 2 write beats to line 0x040; release; then read 0x040.
  - Response: all outputs at reset values immediately (asynchronously); no wr_done_o; the read returns new data in words 0–1 and old data in words 2–3.
- Line wrap:
  - Stimulus: read at addr 0xFFC.
  - Response: beats from words 0x3FC..0x3FF only; the index does not spill to word 0.
